// File: rtl/switch_allocator_pkg.sv
`default_nettype none
// ============================================================================
// Module  : noc_params (package)
// Brief   : Shared router widths and types for the switch allocator slice.
// Revision: 1.0 - initial release
// ============================================================================
package noc_params;

    localparam int VC_NUM     = 2;
    localparam int VC_SIZE    = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;
    localparam int PORT_COUNT = 5;
    localparam int PORT_SIZE  = (PORT_COUNT > 1) ? $clog2(PORT_COUNT) : 1;

    typedef logic [PORT_SIZE-1:0] port_t;

endpackage
`default_nettype wire

// File: rtl/round_robin_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : round_robin_arbiter
// Brief   : N-way round-robin arbiter; pointer advances past the winner only
//           when the caller confirms the grant.
// Revision: 1.0 - initial release
// ============================================================================
module round_robin_arbiter #(
    parameter int N = 2,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  request_i,
    input  logic          grant_en_i,
    output logic [N-1:0]  grant_o,
    output logic [IW-1:0] grant_idx_o,
    output logic          any_grant_o
);

    logic [IW-1:0] r_ptr;
    logic [IW:0]   w_sum;
    logic [IW-1:0] w_idx;

    // Scan upward from the pointer, wrapping at N; first requester wins.
    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        any_grant_o = 1'b0;
        w_sum       = '0;
        w_idx       = '0;
        for (int k = 0; k < N; k++) begin
            w_sum = {1'b0, r_ptr} + (IW+1)'(k);
            if (w_sum >= (IW+1)'(N)) begin
                w_sum = w_sum - (IW+1)'(N);
            end
            w_idx = w_sum[IW-1:0];
            if (!any_grant_o && request_i[w_idx]) begin
                any_grant_o    = 1'b1;
                grant_idx_o    = w_idx;
                grant_o[w_idx] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (grant_en_i && any_grant_o) begin
            r_ptr <= (grant_idx_o == IW'(N-1)) ? '0 : grant_idx_o + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/switch_allocator.sv
`default_nettype none
// ============================================================================
// Module  : switch_allocator
// Brief   : Separable input-first switch allocator with registered crossbar
//           selects. Optional starvation monitor: SA_STARVATION_CHECK_EN.
// Revision: 1.0 - initial release
// ============================================================================
module switch_allocator
    import noc_params::*;
#(
    parameter int PORT_NUM     = PORT_COUNT,
    parameter int STARVE_LIMIT = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [VC_NUM-1:0]   switch_request_i [PORT_NUM],
    input  port_t               out_port_i       [PORT_NUM][VC_NUM],
    input  logic [VC_SIZE-1:0]  downstream_vc_i  [PORT_NUM][VC_NUM],
    input  logic [VC_NUM-1:0]   on_off_i         [PORT_NUM],
    output logic [PORT_NUM-1:0] valid_sel_o,
    output logic [VC_SIZE-1:0]  vc_sel_o         [PORT_NUM],
    output port_t               xb_sel_o         [PORT_NUM],
    output logic [PORT_NUM-1:0] xb_valid_o,
    output logic [VC_NUM-1:0]   starve_o         [PORT_NUM]
);

    if (STARVE_LIMIT < 1) begin : g_bad_limit
        $error("STARVE_LIMIT must be at least 1");
    end

    logic [VC_NUM-1:0]   w_eligible [PORT_NUM];
    logic [VC_NUM-1:0]   w_s1_grant [PORT_NUM];
    logic [VC_SIZE-1:0]  w_s1_vc    [PORT_NUM];
    logic [PORT_NUM-1:0] w_s1_any;
    port_t               w_s1_target[PORT_NUM];
    logic [PORT_NUM-1:0] w_s2_req   [PORT_NUM];
    logic [PORT_NUM-1:0] w_s2_grant [PORT_NUM];
    port_t               w_s2_idx   [PORT_NUM];
    logic [PORT_NUM-1:0] w_s2_any;
    logic [PORT_NUM-1:0] w_valid_sel;

    // Out-of-range routes are never eligible so on_off_i is not over-indexed.
    always_comb begin
        for (int i = 0; i < PORT_NUM; i++) begin
            for (int v = 0; v < VC_NUM; v++) begin
                w_eligible[i][v] = 1'b0;
                if (switch_request_i[i][v] && (int'(out_port_i[i][v]) < PORT_NUM)) begin
                    w_eligible[i][v] = on_off_i[out_port_i[i][v]][downstream_vc_i[i][v]];
                end
            end
        end
    end

    for (genvar i = 0; i < PORT_NUM; i++) begin : g_in_arb
        round_robin_arbiter #(.N(VC_NUM)) u_in_arb (
            .clk        (clk),
            .rst        (rst),
            .request_i  (w_eligible[i]),
            .grant_en_i (w_valid_sel[i]),
            .grant_o    (w_s1_grant[i]),
            .grant_idx_o(w_s1_vc[i]),
            .any_grant_o(w_s1_any[i])
        );
    end

    always_comb begin
        for (int i = 0; i < PORT_NUM; i++) begin
            w_s1_target[i] = '0;
            for (int v = 0; v < VC_NUM; v++) begin
                if (w_s1_grant[i][v]) begin
                    w_s1_target[i] = out_port_i[i][v];
                end
            end
        end
        for (int o = 0; o < PORT_NUM; o++) begin
            for (int i = 0; i < PORT_NUM; i++) begin
                w_s2_req[o][i] = w_s1_any[i] && (w_s1_target[i] == port_t'(o));
            end
        end
    end

    for (genvar o = 0; o < PORT_NUM; o++) begin : g_out_arb
        round_robin_arbiter #(.N(PORT_NUM)) u_out_arb (
            .clk        (clk),
            .rst        (rst),
            .request_i  (w_s2_req[o]),
            .grant_en_i (w_s2_any[o]),
            .grant_o    (w_s2_grant[o]),
            .grant_idx_o(w_s2_idx[o]),
            .any_grant_o(w_s2_any[o])
        );
    end

    // Each input targets a single output, so OR-ing the columns is one-hot safe.
    always_comb begin
        for (int i = 0; i < PORT_NUM; i++) begin
            w_valid_sel[i] = 1'b0;
            for (int o = 0; o < PORT_NUM; o++) begin
                w_valid_sel[i] = w_valid_sel[i] | w_s2_grant[o][i];
            end
            w_valid_sel[i] = w_valid_sel[i] & ~rst;
            vc_sel_o[i]    = w_valid_sel[i] ? w_s1_vc[i] : '0;
        end
        valid_sel_o = w_valid_sel;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            xb_valid_o <= '0;
            for (int o = 0; o < PORT_NUM; o++) begin
                xb_sel_o[o] <= '0;
            end
        end else begin
            xb_valid_o <= w_s2_any;
            for (int o = 0; o < PORT_NUM; o++) begin
                if (w_s2_any[o]) begin
                    xb_sel_o[o] <= w_s2_idx[o];
                end
            end
        end
    end

`ifdef SA_STARVATION_CHECK_EN
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic [SW-1:0]     r_starve_cnt [PORT_NUM][VC_NUM];
    logic [VC_NUM-1:0] r_starve     [PORT_NUM];

    // Counter saturates at the limit; the flag latches on the edge it gets there.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < PORT_NUM; i++) begin
                r_starve[i] <= '0;
                for (int v = 0; v < VC_NUM; v++) begin
                    r_starve_cnt[i][v] <= '0;
                end
            end
        end else begin
            for (int i = 0; i < PORT_NUM; i++) begin
                for (int v = 0; v < VC_NUM; v++) begin
                    if (!switch_request_i[i][v] || (w_valid_sel[i] && w_s1_grant[i][v])) begin
                        r_starve_cnt[i][v] <= '0;
                    end else if (r_starve_cnt[i][v] != SW'(STARVE_LIMIT)) begin
                        r_starve_cnt[i][v] <= r_starve_cnt[i][v] + 1'b1;
                        if (r_starve_cnt[i][v] == SW'(STARVE_LIMIT - 1)) begin
                            r_starve[i][v] <= 1'b1;
                        end
                    end
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < PORT_NUM; i++) begin
            starve_o[i] = r_starve[i];
        end
    end
`else
    always_comb begin
        for (int i = 0; i < PORT_NUM; i++) begin
            starve_o[i] = '0;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_switch_allocator.sv
`default_nettype none
// ============================================================================
// Module  : tb_switch_allocator
// Brief   : Directed self-checking bench for switch_allocator.
// Revision: 1.0 - initial release
// ============================================================================
module tb_switch_allocator;
    import noc_params::*;

    localparam int PN = 5;
`ifdef SA_STARVATION_CHECK_EN
    localparam bit STARVE_ON = 1'b1;
`else
    localparam bit STARVE_ON = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [VC_NUM-1:0] req      [PN];
    port_t             out_port [PN][VC_NUM];
    logic [VC_SIZE-1:0] dvc     [PN][VC_NUM];
    logic [VC_NUM-1:0] on_off   [PN];
    logic [PN-1:0]     valid_sel;
    logic [VC_SIZE-1:0] vc_sel  [PN];
    port_t             xb_sel   [PN];
    logic [PN-1:0]     xb_valid;
    logic [VC_NUM-1:0] starve   [PN];

    int n_total = 0;
    int n_bad   = 0;

    switch_allocator #(.PORT_NUM(PN), .STARVE_LIMIT(4)) dut (
        .clk             (clk),
        .rst             (rst),
        .switch_request_i(req),
        .out_port_i      (out_port),
        .downstream_vc_i (dvc),
        .on_off_i        (on_off),
        .valid_sel_o     (valid_sel),
        .vc_sel_o        (vc_sel),
        .xb_sel_o        (xb_sel),
        .xb_valid_o      (xb_valid),
        .starve_o        (starve)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        for (int i = 0; i < PN; i++) begin
            req[i]    = '0;
            on_off[i] = '1;
            for (int v = 0; v < VC_NUM; v++) begin
                out_port[i][v] = '0;
                dvc[i][v]      = '0;
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    function automatic logic [31:0] starve_word();
        logic [31:0] w;
        w = '0;
        for (int i = 0; i < PN; i++) begin
            for (int v = 0; v < VC_NUM; v++) begin
                w[i*VC_NUM+v] = starve[i][v];
            end
        end
        return w;
    endfunction

    int seq [6] = '{0, 1, 3, 0, 1, 3};

    initial begin
        // Reset state, with a live request that must be masked.
        clear_inputs();
        req[2][1]      = 1'b1;
        out_port[2][1] = 3'd4;
        #2;
        chk("rst_valid_sel", 32'(valid_sel), 32'h0);
        chk("rst_xb_valid",  32'(xb_valid),  32'h0);
        chk("rst_starve",    starve_word(),  32'h0);

        // Single request: input 2 VC1 -> output 4.
        do_reset();
        #1;
        chk("single_valid_sel", 32'(valid_sel), 32'h04);
        chk("single_vc_sel",    32'(vc_sel[2]), 32'h1);
        step();
        chk("single_xb_valid",  32'(xb_valid),  32'h10);
        chk("single_xb_sel",    32'(xb_sel[4]), 32'h2);
        req[2] = '0;
        #1;
        chk("single_drop_valid", 32'(valid_sel), 32'h0);
        step();
        chk("single_idle_xb_valid", 32'(xb_valid),  32'h0);
        chk("single_hold_xb_sel",   32'(xb_sel[4]), 32'h2);

        // Stage-1 fairness: input 0 VC0 -> out 1, VC1 -> out 2.
        do_reset();
        clear_inputs();
        req[0]         = 2'b11;
        out_port[0][0] = 3'd1;
        out_port[0][1] = 3'd2;
        #1;
        for (int k = 0; k < 4; k++) begin
            chk("fair_valid_sel", 32'(valid_sel), 32'h01);
            chk("fair_vc_sel",    32'(vc_sel[0]), 32'(k % 2));
            step();
            chk("fair_xb_valid",  32'(xb_valid), (k % 2 == 1) ? 32'h04 : 32'h02);
            chk("fair_xb_sel",    32'(xb_sel[(k % 2 == 1) ? 2 : 1]), 32'h0);
        end

        // Output contention: inputs 0, 1, 3 all -> output 2.
        do_reset();
        clear_inputs();
        req[0] = 2'b01; out_port[0][0] = 3'd2;
        req[1] = 2'b01; out_port[1][0] = 3'd2;
        req[3] = 2'b01; out_port[3][0] = 3'd2;
        #1;
        for (int k = 0; k < 6; k++) begin
            chk("cont_valid_sel", 32'(valid_sel), 32'h1 << seq[k]);
            step();
            chk("cont_xb_valid",  32'(xb_valid),  32'h04);
            chk("cont_xb_sel",    32'(xb_sel[2]), 32'(seq[k]));
        end

        // Reset mid-traffic, then first grant goes to input 0 VC 0.
        req[0]         = 2'b11;
        out_port[0][1] = 3'd2;
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_valid_sel", 32'(valid_sel), 32'h0);
        chk("midrst_xb_valid",  32'(xb_valid),  32'h0);
        chk("midrst_starve",    starve_word(),  32'h0);
        step();
        rst = 1'b0;
        #1;
        chk("postrst_valid_sel", 32'(valid_sel), 32'h01);
        chk("postrst_vc_sel",    32'(vc_sel[0]), 32'h0);

        // Flow control: input 1 VC0 -> out 3 downstream VC1, held off.
        do_reset();
        clear_inputs();
        req[1]         = 2'b01;
        out_port[1][0] = 3'd3;
        dvc[1][0]      = 1'b1;
        on_off[3]      = 2'b01;
        #1;
        for (int k = 1; k <= 5; k++) begin
            chk("flow_off_valid_sel", 32'(valid_sel), 32'h0);
            step();
            chk("flow_starve", starve_word(), (STARVE_ON && k >= 4) ? 32'h4 : 32'h0);
        end
        on_off[3] = 2'b11;
        #1;
        chk("flow_on_valid_sel", 32'(valid_sel), 32'h02);
        chk("flow_on_vc_sel",    32'(vc_sel[1]), 32'h0);
        step();
        chk("flow_xb_valid", 32'(xb_valid),  32'h08);
        chk("flow_xb_sel",   32'(xb_sel[3]), 32'h1);
        clear_inputs();
        step();
        step();
        chk("starve_sticky", starve_word(), STARVE_ON ? 32'h4 : 32'h0);
        do_reset();
        #1;
        chk("starve_cleared", starve_word(), 32'h0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/switch_allocator.md
# switch_allocator

Separable input-first switch allocator for one router. It shares the crossbar between the `PORT_NUM` input ports. Each cycle it picks at most one virtual channel per input port and at most one input port per output port, honouring downstream on/off flow control. It returns the grants to the input ports in the same cycle and drives registered crossbar select lines for the switch-traversal stage one cycle later.

## Interface
Parameters:
- `PORT_NUM`, 5, number of router ports; inputs and outputs are indexed identically.
- `STARVE_LIMIT`, 16, consecutive denied cycles before a VC is flagged starved. Used only with the macro defined.

Ports:
- `clk` input 1: router clock.
- `rst` input 1: reset. **Reset is asynchronous and active-high.** One clock domain only.
- `switch_request_i` input `[VC_NUM-1:0]` x `PORT_NUM`: per input VC, a flit is ready for switch traversal.
- `out_port_i` input `port_t [VC_NUM-1:0]` x `PORT_NUM`: routed output port per input VC.
- `downstream_vc_i` input `[VC_SIZE-1:0]` x `VC_NUM` x `PORT_NUM`: allocated downstream VC per input VC.
- `on_off_i` input `[VC_NUM-1:0]` x `PORT_NUM`, indexed by output port: 1 means the downstream VC accepts flits.
- `valid_sel_o` output 1 x `PORT_NUM`: input port granted this cycle.
- `vc_sel_o` output `[VC_SIZE-1:0]` x `PORT_NUM`: granted VC index. Holds 0 when `valid_sel_o` is 0.
- `xb_sel_o` output `port_t` x `PORT_NUM`, indexed by output port: input port routed to this output.
- `xb_valid_o` output 1 x `PORT_NUM`: crossbar output carries a flit.
- `starve_o` output `[VC_NUM-1:0]` x `PORT_NUM`: sticky starvation flag.

## Operation
- **Eligibility.** VC v of input i is eligible when `switch_request_i[i][v]` is 1 and `on_off_i[out_port_i[i][v]][downstream_vc_i[i][v]]` is 1.
- **Stage 1 (per input i).**
  - Round-robin over eligible VCs.
  - Search starts at `in_ptr[i]` and proceeds upward, wrapping from `VC_NUM-1` to 0.
  - The first eligible VC is the stage-1 winner.
- **Stage 2 (per output o).**
  - Round-robin over inputs whose stage-1 winner targets o.
  - Search starts at `out_ptr[o]` and wraps from `PORT_NUM-1` to 0.
  - The winning input gets `valid_sel_o`=1 and `vc_sel_o`=its stage-1 VC.
- **Pointer update.**
  - `in_ptr[i]` becomes (granted VC + 1) mod `VC_NUM`, only when input i receives a final grant.
  - `out_ptr[o]` becomes (granted input + 1) mod `PORT_NUM`, only when output o grants.
  - A losing stage-1 winner leaves its pointer unchanged, so it retries first next cycle.
- **Grant shape.**
  - At most one grant per input and per output.
  - An input never wins two outputs.
  - U-turns (o == i) are allowed; the routing function prevents them.
- **Crossbar registers.** On each clock edge, `xb_valid_o[o]` <= output o granted and `xb_sel_o[o]` <= winner index. When there is no grant: `xb_valid_o`=0 and `xb_sel_o` holds its previous value.
- **Reset.**
  - All pointers, `xb_sel_o`, `xb_valid_o`, `starve_o` and starvation counters clear to 0.
  - `valid_sel_o` and `vc_sel_o` are forced to 0 while `rst`=1.
  - Reset asserted mid-operation drops in-flight crossbar selects immediately. Input ports must not dequeue in that cycle.
- **Edge cases.**
  - All requests ineligible because downstream is off: no grants, pointers unchanged.
  - `switch_request_i` deasserting after a grant needs no handshake. Grants are single-cycle.

## Timing
- `valid_sel_o` / `vc_sel_o`: combinational from inputs and pointers, in the same cycle as the request (zero-cycle latency).
- Crossbar select: one cycle after the grant, aligned with the input port's registered flit output.
- Pointers take their new value on the edge following the grant.
- The combinational path goes from request inputs through both arbiter stages; no internal registers lie on the grant path.

## Configuration
- Macro `SA_STARVATION_CHECK_EN`.
- **Defined:**
  - Each input VC has a saturating counter of `$clog2(STARVE_LIMIT+1)` bits.
  - The counter increments each cycle the VC is requesting and not granted.
  - It clears on grant or when the request drops.
  - When the counter reaches `STARVE_LIMIT`, `starve_o[i][v]` sets and stays set until reset.
- **Undefined:** counters are absent and `starve_o` is tied to 0. Arbitration is identical in both builds.

## Structure
- `noc_params` package holds:
  - `VC_NUM` and `VC_SIZE`;
  - `port_t`;
  - `PORT_NUM`-derived width constants.
- Sub-module `round_robin_arbiter` (parameter `N`), instanced `PORT_NUM` times with `N=VC_NUM` and `PORT_NUM` times with `N=PORT_NUM`:
  - inputs: request vector, grant-enable for the pointer update;
  - outputs: one-hot grant, grant index, any-grant;
  - contains its own pointer register with asynchronous reset.

## Test plan
- **Reset:** assert `rst` mid-traffic -> `valid_sel_o`, `xb_valid_o` and `starve_o` are all 0 immediately; after release, the first grant goes to VC 0 / input 0.
- **Single request:** input 2 VC 1 to output 4, `on_off_i[4]`=all ones -> `valid_sel_o[2]`=1 and `vc_sel_o[2]`=1 in the same cycle; the next cycle gives `xb_valid_o[4]`=1 and `xb_sel_o[4]`=2.
- **Output contention:** inputs 0, 1 and 3 all target output 2 continuously -> grants rotate 0, 1, 3, 0, …; each input is granted once per 3 cycles.
- **Flow control:** input 1 VC 0 targets output 3, downstream VC 1, with `on_off_i[3][1]`=0 -> no grant for 5 cycles; raising it gives a grant in that cycle.
- **Stage-1 fairness:** input 0 has both VCs requesting output 1 and output 2, with no competition -> granted VC alternates 0, 1, 0, 1.
- **Starvation (macro defined, `STARVE_LIMIT`=4):** on_off held low for a requesting VC -> `starve_o` rises after the 4th denied cycle and stays high after traffic clears, until `rst`.
